// File: rtl/nl_vc_credit_pool_pkg.sv
// nl_vc_credit_pool_pkg: shared flit type, VC reuse-mode encodings and one-hot helpers
package nl_vc_credit_pool_pkg;
  localparam int NL_NUM_VCS = 4;
  localparam int NL_ID_W = $clog2(NL_NUM_VCS);
  localparam int REUSE_ON_TAIL = 0;
  localparam int REUSE_ON_DRAIN = 1;
  typedef struct packed {
    logic tail;
    logic [NL_NUM_VCS-1:0] vc_id;
  } flit_ctrl_t;
  typedef struct packed {
    flit_ctrl_t control;
  } flit_t;
  function automatic logic [NL_ID_W-1:0] oh2bin(input logic [NL_NUM_VCS-1:0] oh);
    logic [NL_ID_W-1:0] b;
    b = '0;
    for (int i = 0; i < NL_NUM_VCS; i++) b |= oh[i] ? NL_ID_W'(i) : '0;
    return b;
  endfunction
  function automatic logic [NL_NUM_VCS-1:0] bin2oh(input logic [NL_ID_W-1:0] b);
    return NL_NUM_VCS'(1) << b;
  endfunction
endpackage

// File: rtl/nl_id_fifo.sv
// nl_id_fifo: synchronous id FIFO preloaded with 0..PRELOAD-1, push and pop allowed in one cycle
module nl_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4,
  parameter int PRELOAD = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_id,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign head = mem[rd_ptr];
  assign empty = count == '0;
  // ring buffer; reset preloads ids in ascending order
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(i < PRELOAD ? i : 0);
      rd_ptr <= '0;
      wr_ptr <= PW'(PRELOAD % DEPTH);
      count <= CW'(PRELOAD);
    end else begin
      if (push) mem[wr_ptr] <= push_id;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/nl_vc_credit_pool.sv
// nl_vc_credit_pool: per-output-port VC free pool with downstream credit tracking
module nl_vc_credit_pool
  import nl_vc_credit_pool_pkg::*;
#(
  parameter int NUM_VCS_GLOBAL = 4,
  parameter int NUM_VCS_LOCAL = 4,
  parameter int BUF_DEPTH = 4,
  parameter int REUSE_MODE = REUSE_ON_DRAIN,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int ID_W = $clog2(NUM_VCS_GLOBAL)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  flit_t                     flit,
  input  logic                      valid,
  input  logic                      credit_valid,
  input  logic [NUM_VCS_GLOBAL-1:0] credit_vc,
  input  logic                      alloc_req,
  output logic                      alloc_gnt,
  output logic [NUM_VCS_GLOBAL-1:0] alloc_vc,
  output logic [ID_W:0]             free_count,
  output logic [NUM_VCS_GLOBAL-1:0] vc_alloc_status,
  output logic [NUM_VCS_GLOBAL-1:0] vc_credit_ok,
  output logic                      err
);
  localparam logic [NUM_VCS_GLOBAL-1:0] LOCAL_MASK = NUM_VCS_GLOBAL'((64'd1 << NUM_VCS_LOCAL) - 64'd1);
  logic [CNT_W-1:0] credits [NUM_VCS_GLOBAL];
  logic [NUM_VCS_GLOBAL-1:0] pending, queued, fl_oh, dep, ret, tail_now, full, no_cr, elig, push_oh, pop_oh;
  logic [ID_W-1:0] head, push_id;
  logic fifo_empty, push, flit_err, credit_err, vc_err, oh_err;
  function automatic logic is_oh(input logic [NUM_VCS_GLOBAL-1:0] x);
    return x != '0 && (x & (x - NUM_VCS_GLOBAL'(1))) == '0;
  endfunction
  assign fl_oh = NUM_VCS_GLOBAL'(flit.control.vc_id);
  assign dep = valid ? fl_oh : '0;
  assign ret = credit_valid ? credit_vc : '0;
  assign tail_now = flit.control.tail ? dep : '0;
  // per-VC credit status from the registered counters
  always_comb begin
    full = '0;
    no_cr = '0;
    for (int v = 0; v < NUM_VCS_GLOBAL; v++) begin
      full[v] = credits[v] == CNT_W'(BUF_DEPTH);
      no_cr[v] = credits[v] == '0;
    end
  end
  assign elig = (REUSE_MODE == REUSE_ON_TAIL) ? (pending | tail_now) : (pending & full);
  assign push_oh = elig & (~elig + NUM_VCS_GLOBAL'(1));
  assign push = |elig;
  assign push_id = ID_W'(oh2bin(NL_NUM_VCS'(push_oh)));
  assign alloc_gnt = alloc_req && !fifo_empty;
  assign alloc_vc = fifo_empty ? '0 : NUM_VCS_GLOBAL'(bin2oh(NL_ID_W'(head)));
  assign pop_oh = alloc_gnt ? alloc_vc : '0;
  assign vc_alloc_status = queued;
  assign vc_credit_ok = ~no_cr;
  assign flit_err = |(dep & ~ret & no_cr);
  assign credit_err = |(ret & ~dep & full);
  assign vc_err = valid && |(fl_oh & (queued | ~LOCAL_MASK));
  assign oh_err = (valid && !is_oh(fl_oh)) || (credit_valid && !is_oh(credit_vc));
  nl_id_fifo #(
    .W(ID_W),
    .DEPTH(NUM_VCS_GLOBAL),
    .PRELOAD(NUM_VCS_LOCAL)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_id(push_id),
    .pop(alloc_gnt),
    .head(head),
    .count(free_count),
    .empty(fifo_empty)
  );
  // saturating credit counters, release bookkeeping and sticky error flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS_GLOBAL; v++) credits[v] <= (v < NUM_VCS_LOCAL) ? CNT_W'(BUF_DEPTH) : '0;
      pending <= '0;
      queued <= LOCAL_MASK;
      err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS_GLOBAL; v++)
        credits[v] <= (dep[v] && !ret[v] && !no_cr[v]) ? credits[v] - CNT_W'(1) :
                      (ret[v] && !dep[v] && !full[v]) ? credits[v] + CNT_W'(1) : credits[v];
      pending <= (pending | tail_now) & ~push_oh;
      queued <= (queued & ~pop_oh) | push_oh;
      err <= err | flit_err | credit_err | vc_err | oh_err;
    end
`ifdef DEBUG
  // protocol checks mirrored by the err flag
  always_ff @(posedge clk)
    if (rst_n) begin
      assert (!flit_err) else $error("flit on VC with no credits");
      assert (!credit_err) else $error("credit return on VC with full credits");
      assert (!vc_err) else $error("flit on queued or non-local VC");
      assert (!oh_err) else $error("vc_id or credit_vc not one-hot");
    end
`endif
endmodule

// File: tb/tb_nl_vc_credit_pool.sv
// tb_nl_vc_credit_pool: scoreboard bench for the VC credit pool in drain and tail reuse modes
module tb_nl_vc_credit_pool;
  import nl_vc_credit_pool_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  flit_t flit = '0;
  logic valid = 1'b0;
  logic credit_valid = 1'b0;
  logic alloc_req = 1'b0;
  logic [3:0] credit_vc = '0;
  logic gnt1, gnt0, err1, err0;
  logic [3:0] vc1, vc0, st1, st0, ok1, ok0, e1, e0;
  logic [2:0] fc1, fc0;
  int checks = 0;
  int errors = 0;
  logic [3:0] q1 [$];
  logic [3:0] q0 [$];
  always #5 clk = ~clk;
  nl_vc_credit_pool #(.REUSE_MODE(REUSE_ON_DRAIN)) u1 (
    .clk(clk), .rst_n(rst_n), .flit(flit), .valid(valid), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .alloc_req(alloc_req), .alloc_gnt(gnt1), .alloc_vc(vc1),
    .free_count(fc1), .vc_alloc_status(st1), .vc_credit_ok(ok1), .err(err1)
  );
  nl_vc_credit_pool #(.REUSE_MODE(REUSE_ON_TAIL)) u0 (
    .clk(clk), .rst_n(rst_n), .flit(flit), .valid(valid), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .alloc_req(alloc_req), .alloc_gnt(gnt0), .alloc_vc(vc0),
    .free_count(fc0), .vc_alloc_status(st0), .vc_credit_ok(ok0), .err(err0)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask
  // grant monitor: each grant pops the VC the stimulus predicted
  always @(negedge clk)
    if (rst_n) begin
      if (gnt1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL drain_grant actual %b expected no grant", vc1);
        end else begin
          e1 = q1.pop_front();
          if (vc1 !== e1) begin
            errors++;
            $display("FAIL drain_grant actual %b expected %b", vc1, e1);
          end
        end
      end
      if (gnt0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL tail_grant actual %b expected no grant", vc0);
        end else begin
          e0 = q0.pop_front();
          if (vc0 !== e0) begin
            errors++;
            $display("FAIL tail_grant actual %b expected %b", vc0, e0);
          end
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
    valid = 1'b0;
    credit_valid = 1'b0;
    alloc_req = 1'b0;
    credit_vc = '0;
    flit = '0;
  endtask
  task automatic alloc(input logic [3:0] x1, input logic [3:0] x0);
    alloc_req = 1'b1;
    q1.push_back(x1);
    q0.push_back(x0);
    tick();
  endtask
  task automatic send(input logic [3:0] vc, input logic tl);
    valid = 1'b1;
    flit.control.vc_id = vc;
    flit.control.tail = tl;
    tick();
  endtask
  task automatic cred(input logic [3:0] vc);
    credit_valid = 1'b1;
    credit_vc = vc;
    tick();
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_free_count", fc1, 4);
    chk("rst_status", st1, 4'hf);
    chk("rst_credit_ok", ok1, 4'hf);
    chk("rst_err", err1, 0);
    chk("rst_head", vc1, 4'b0001);
    chk("rst_gnt_idle", gnt1, 0);
    chk("rst_free_count_t", fc0, 4);
    @(posedge clk);
    #1;
    alloc(4'b0001, 4'b0001);
    alloc(4'b0010, 4'b0010);
    alloc(4'b0100, 4'b0100);
    chk("pop3_free_count", fc1, 1);
    chk("pop3_status", st1, 4'h8);
    chk("pop3_credit_ok", ok1, 4'hf);
    chk("pop3_free_count_t", fc0, 1);
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b1);
    chk("tail_drain_not_queued", st1, 4'h8);
    chk("tail_mode0_queued", st0, 4'h9);
    chk("tail_mode0_count", fc0, 2);
    chk("tail_credit_ok", ok1, 4'hf);
    cred(4'b0001);
    cred(4'b0001);
    chk("drain_partial", st1, 4'h8);
    cred(4'b0001);
    chk("drain_full_not_yet", st1, 4'h8);
    chk("drain_full_count", fc1, 1);
    tick();
    chk("drain_pushed", st1, 4'h9);
    chk("drain_pushed_count", fc1, 2);
    alloc(4'b1000, 4'b1000);
    alloc(4'b0001, 4'b0001);
    chk("empty_count", fc1, 0);
    chk("empty_status", st1, 0);
    chk("empty_count_t", fc0, 0);
    alloc_req = 1'b1;
    #1;
    chk("empty_gnt", gnt1, 0);
    chk("empty_vc", vc1, 0);
    chk("empty_gnt_t", gnt0, 0);
    tick();
    chk("no_err_drain", err1, 0);
    chk("no_err_tail", err0, 0);
    send(4'b0100, 1'b0);
    send(4'b0100, 1'b0);
    send(4'b0100, 1'b1);
    chk("m0_vc2_queued", st0, 4'h4);
    chk("m0_vc2_count", fc0, 1);
    chk("m1_vc2_pending", st1, 0);
    valid = 1'b1;
    flit.control.vc_id = 4'b0010;
    credit_valid = 1'b1;
    credit_vc = 4'b0010;
    tick();
    chk("same_cycle_credits", u1.credits[1], 4);
    chk("same_cycle_credits_t", u0.credits[1], 4);
    chk("same_cycle_err", err1, 0);
    cred(4'b0100);
    cred(4'b0100);
    cred(4'b0100);
    chk("vc2_drain_wait", st1, 0);
    tick();
    chk("vc2_drain_pushed", st1, 4'h4);
    chk("vc2_drain_count", fc1, 1);
    chk("vc2_tail_status", st0, 4'h4);
    alloc_req = 1'b1;
    q1.push_back(4'b0100);
    q0.push_back(4'b0100);
    valid = 1'b1;
    flit.control.vc_id = 4'b0010;
    flit.control.tail = 1'b1;
    tick();
    chk("pushpop_count", fc0, 1);
    chk("pushpop_head", vc0, 4'b0010);
    chk("pushpop_drain_count", fc1, 0);
    cred(4'b0010);
    tick();
    chk("vc1_drain_pushed", st1, 4'h2);
    chk("vc1_drain_count", fc1, 1);
    alloc(4'b0010, 4'b0010);
    valid = 1'b1;
    flit.control.vc_id = 4'b1010;
    flit.control.tail = 1'b1;
    credit_valid = 1'b1;
    credit_vc = 4'b1010;
    tick();
    chk("prio_first_t", st0, 4'h2);
    chk("prio_first_count_t", fc0, 1);
    chk("prio_none_yet", st1, 0);
    chk("oh_err", err1, 1);
    chk("oh_err_t", err0, 1);
    tick();
    chk("prio_second_t", st0, 4'ha);
    chk("prio_head_t", vc0, 4'b0010);
    chk("prio_first", st1, 4'h2);
    tick();
    chk("prio_second", st1, 4'ha);
    chk("prio_count", fc1, 2);
    alloc(4'b0010, 4'b0010);
    alloc(4'b1000, 4'b1000);
    chk("prio_drained", fc1, 0);
    send(4'b0001, 1'b1);
    send(4'b0010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", fc1, 4);
    chk("async_status", st1, 4'hf);
    chk("async_credit_ok", ok1, 4'hf);
    chk("async_err", err1, 0);
    chk("async_head", vc1, 4'b0001);
    chk("async_count_t", fc0, 4);
    chk("async_status_t", st0, 4'hf);
    chk("async_err_t", err0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("no_stale_release", fc1, 4);
    chk("no_stale_release_t", fc0, 4);
    alloc(4'b0001, 4'b0001);
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b0);
    chk("zero_credit_ok", ok1, 4'he);
    chk("zero_no_err", err1, 0);
    send(4'b0001, 1'b0);
    chk("underflow_err", err1, 1);
    chk("underflow_hold", ok1, 4'he);
    cred(4'b0001);
    chk("underflow_sat", ok1, 4'hf);
    tick();
    chk("err_sticky", err1, 1);
    do_reset();
    chk("reset_err_clear", err1, 0);
    cred(4'b0100);
    chk("overflow_err", err1, 1);
    chk("overflow_hold", u1.credits[2], 4);
    do_reset();
    chk("reset_err_clear2", err1, 0);
    send(4'b0001, 1'b0);
    chk("queued_flit_err", err1, 1);
    chk("queued_flit_err_t", err0, 1);
    tick();
    chk("queued_err_sticky", err1, 1);
    do_reset();
    chk("final_err_clear", err1, 0);
    chk("drain_sb_empty", 8'(q1.size()), 0);
    chk("tail_sb_empty", 8'(q0.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nl_vc_credit_pool.md
# nl_vc_credit_pool

Per-output-port VC free pool with credit tracking. It replaces the status-bitmask free pool. Freed VCs are served in strict release order from an internal FIFO. Each VC carries a downstream credit counter, and a VC can optionally be recycled only once its downstream buffer has fully drained. One instance sits on each output port, between the VC allocator (pop handshake) and the output link (departing flits, returning credits).

## Interface
Parameters:
- NUM_VCS_GLOBAL, 4, VCs per router; width of all VC masks.
- NUM_VCS_LOCAL, 4, VCs usable at this port; VCs 0..NUM_VCS_LOCAL-1 are active, the rest are never offered.
- BUF_DEPTH, 4, downstream flit slots per VC (initial credits).
- REUSE_MODE, 1, release policy: 0 releases on tail departure; 1 releases on tail departure AND credits==BUF_DEPTH.
- Derived (localparam): CNT_W=$clog2(BUF_DEPTH+1), ID_W=$clog2(NUM_VCS_GLOBAL).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset. One clock; reset is asynchronous and active-low.
- flit, in, flit_t, departing flit; uses control.tail and control.vc_id (one-hot).
- valid, in, 1, flit departs on the output link this cycle.
- credit_valid, in, 1, downstream returns one credit.
- credit_vc, in, NUM_VCS_GLOBAL, one-hot VC of the returned credit.
- alloc_req, in, 1, allocator requests a VC.
- alloc_gnt, out, 1, combinational; alloc_req && FIFO non-empty.
- alloc_vc, out, NUM_VCS_GLOBAL, one-hot FIFO head VC; 0 when FIFO empty.
- free_count, out, ID_W+1, entries in FIFO.
- vc_alloc_status, out, NUM_VCS_GLOBAL, VCs currently queued (free).
- vc_credit_ok, out, NUM_VCS_GLOBAL, credits[v]!=0.
- err, out, 1, sticky protocol-error flag.

## Operation
- State per VC:
  - credits[v] (CNT_W bits).
  - pending[v]: tail has departed, release not yet done.
  - queued[v]: VC is in the FIFO.
- Shared state: FIFO of ID_W-bit VC ids, depth NUM_VCS_GLOBAL, with rd/wr pointers and count.
- Reset values:
  - FIFO holds 0,1,..,NUM_VCS_LOCAL-1 in that order; free_count=NUM_VCS_LOCAL.
  - credits = BUF_DEPTH for local VCs, 0 for all others.
  - pending=0, err=0.
- Pop: when alloc_gnt is high, the head is removed at the next edge and queued[head] is cleared.
- Flit departure (valid):
  - credits[vc_id] decrements.
  - If tail, pending[vc_id] is set. This covers single-flit packets too.
- Credit return (credit_valid): credits[credit_vc] increments.
- Departure and return on the same VC in the same cycle: credits unchanged.
- Release:
  - A VC is eligible when pending is set and, in REUSE_MODE=1 only, credits==BUF_DEPTH.
  - At most one push per cycle: the lowest-index eligible VC. Its pending bit clears as it is pushed. Other eligible VCs wait.
  - Eligibility uses registered credits. A tail whose last credit returns in cycle t is pushed at the end of cycle t+1.
- Simultaneous push and pop are both performed; free_count is unchanged. There is no bypass: a VC pushed into an empty FIFO is first offered in the next cycle.
- FIFO cannot overflow, because each VC is queued at most once.
- Errors set err, which stays set until reset. Each of the following is also asserted under `ifdef DEBUG:
  - Flit on a VC with credits==0: counter holds at 0.
  - Credit return with credits==BUF_DEPTH: counter holds.
  - Flit on a VC that is queued, or that is non-local.
  - Non-one-hot vc_id or credit_vc while valid/credit_valid is high.

## Timing
- All state is registered on the posedge of clk; rst_n clears asynchronously.
- alloc_gnt and alloc_vc are combinational from alloc_req and the FIFO head register, with zero latency.
- vc_alloc_status, vc_credit_ok and free_count come straight from registers.
- Release latency: tail departs in cycle t (mode 0) → VC visible at the head no earlier than t+1 and pushed at the end of t.
- Reset asserted mid-operation discards all pending and queued state and restores the reset values immediately. Packets in flight are the caller's concern.

## Structure
- The codebase's shared package supplies flit_t.
- Add to that package: the REUSE_MODE encodings (REUSE_ON_TAIL=0, REUSE_ON_DRAIN=1) and the oh2bin/bin2oh helpers.
- One sub-module: nl_id_fifo, a parametrised synchronous FIFO of ID_W-bit ids. It has a reset-preload parameter, count output, and allows push and pop in the same cycle.
- Credit counters, pending bits and the release priority encoder live in the top module.

## Test plan
- Reset, mode 1, 4 local of 4 global: three alloc_req pulses → alloc_vc = 0001, 0010, 0100; free_count goes 4→1; credits all 4.
- Mode 1 lifecycle: allocate VC0, send 3 flits with tail last → credits 1, pending set. Return 3 credits → VC0 pushed one cycle after credits reach 4, and is the last in the FIFO.
- Mode 0: tail on VC2 with credits=2 → VC2 queued at the next edge. Same-cycle flit + credit on VC1 → credits unchanged.
- VC1 and VC3 become eligible in the same cycle → VC1 pushed first, VC3 the following cycle. FIFO holding 1 entry with simultaneous pop and push → free_count stays 1, the new VC is at the head next cycle.
- Error cases: flit on a VC with 0 credits, credit on a full VC, flit on a queued VC → err=1 and stays 1; counters saturate.
- Reset asserted mid-packet with pending set → all outputs return to reset values without waiting for a clock edge.
